// File: rtl/mining_sequencer_pkg.sv
// Shared definitions for the SHA-256 mining sequencer slice:
// datapath state codes, bus widths and the sequencer's FSM states.
package mining_sequencer_pkg;

    localparam int BLOCK_W = 512;
    localparam int HASH_W  = 256;
    localparam int NONCE_W = 32;
    localparam int SLICE_W = 64;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_INIT  = 3'd2;
    localparam logic [2:0] ST_FETCH = 3'd3;
    localparam logic [2:0] ST_SCHED = 3'd4;
    localparam logic [2:0] ST_ROUND = 3'd5;
    localparam logic [2:0] ST_OUT   = 3'd6;
    localparam logic [2:0] ST_CMP   = 3'd0;
    localparam logic [2:0] ST_DONE  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_FETCH,
        S_SCHED,
        S_ROUND,
        S_OUT,
        S_CMP,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/mining_sequencer_if.sv
// Host block-load channel: valid/ready handshake plus the
// write-pointer clear strobe.
interface mining_sequencer_if;
    import mining_sequencer_pkg::*;

    logic               load_valid;
    logic               load_ready;
    logic               load_clear;
    logic [BLOCK_W-1:0] load_data;

    modport master (
        output load_valid,
        output load_data,
        output load_clear,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_clear,
        output load_ready
    );

endinterface

// File: rtl/mining_sequencer_cmp.sv
// Registered 256-bit unsigned less-than, evaluated as four 64-bit
// slices so each compare is short; the slice results merge MSB-first.
module hash_target_cmp
    import mining_sequencer_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [HASH_W-1:0] hash,
    input  logic [HASH_W-1:0] target,
    output logic              lt
);

    logic [3:0] slice_lt;
    logic [3:0] slice_eq;

    always_ff @(posedge clock) begin
        if (reset) begin
            slice_lt <= '0;
            slice_eq <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                slice_lt[i] <= hash[i*SLICE_W +: SLICE_W]
                             < target[i*SLICE_W +: SLICE_W];
                slice_eq[i] <= hash[i*SLICE_W +: SLICE_W]
                            == target[i*SLICE_W +: SLICE_W];
            end
        end
    end

    always_comb begin
        lt = slice_lt[3]
           | (slice_eq[3] & slice_lt[2])
           | (slice_eq[3] & slice_eq[2] & slice_lt[1])
           | (slice_eq[3] & slice_eq[2] & slice_eq[1] & slice_lt[0]);
    end

endmodule

// File: rtl/mining_sequencer.sv
// Mining control FSM: stores host blocks, then runs nonce attempts
// over all stored blocks and compares each hash against the target.
module mining_sequencer
    import mining_sequencer_pkg::*;
#(
    parameter int DEPTH        = 2000,
    parameter int ADDR_W       = 16,
    parameter int ROUND_CYCLES = 1
) (
    input  logic               clock,
    input  logic               reset,
    mining_sequencer_if.slave  load,
    input  logic               start,
    input  logic               abort,
    input  logic [ADDR_W-1:0]  nonce_addr,
    input  logic [8:0]         nonce_msb,
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [31:0]        max_attempts,
    input  logic [HASH_W-1:0]  target,
    output logic [2:0]         dp_state,
    output logic [ADDR_W-1:0]  dp_addr,
    output logic [BLOCK_W-1:0] dp_message,
    output logic               dp_stopw,
    output logic [8:0]         dp_width,
    output logic [ADDR_W-1:0]  dp_nonce_addr,
    input  logic [HASH_W-1:0]  dp_hash,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic [NONCE_W-1:0] found_nonce,
    output logic [31:0]        attempts
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [6:0]      RC_LAST = 7'(ROUND_CYCLES - 1);

    seq_state_t         state;
    logic [ADDR_W:0]    wr_ptr;
    logic [ADDR_W-1:0]  last;
    logic [ADDR_W-1:0]  blk;
    logic [6:0]         rcnt;
    logic [NONCE_W-1:0] nonce;
    logic [31:0]        max_q;
    logic [HASH_W-1:0]  target_q;
    logic               hit;

    logic [ADDR_W:0]    ptr_inc;
    logic [31:0]        att_inc;
    logic               ptr_room;
    logic               ptr_room_inc;

    assign ptr_inc      = wr_ptr + (ADDR_W+1)'(1);
    assign att_inc      = attempts + 32'd1;
    assign ptr_room     = wr_ptr < DEPTH_C;
    assign ptr_room_inc = ptr_inc < DEPTH_C;

    // dp_hash is sampled on the edge that enters CMP
    hash_target_cmp u_cmp (
        .clock  (clock),
        .reset  (reset),
        .hash   (dp_hash),
        .target (target_q),
        .lt     (hit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= S_IDLE;
            wr_ptr          <= '0;
            last            <= '0;
            blk             <= '0;
            rcnt            <= '0;
            nonce           <= '0;
            max_q           <= '0;
            target_q        <= '0;
            dp_state        <= ST_IDLE;
            dp_addr         <= '0;
            dp_message      <= '0;
            dp_stopw        <= 1'b1;
            dp_width        <= '0;
            dp_nonce_addr   <= '0;
            load.load_ready <= 1'b1;
            busy            <= 1'b0;
            found           <= 1'b0;
            exhausted       <= 1'b0;
            found_nonce     <= '0;
            attempts        <= '0;
        end else begin
            found     <= 1'b0;
            exhausted <= 1'b0;
            if (abort && state != S_IDLE) begin
                state           <= S_IDLE;
                dp_state        <= ST_IDLE;
                dp_addr         <= last;
                dp_stopw        <= 1'b1;
                busy            <= 1'b0;
                load.load_ready <= ptr_room;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        dp_state <= ST_IDLE;
                        dp_addr  <= last;
                        dp_stopw <= 1'b1;
                        if (load.load_clear) begin
                            wr_ptr          <= '0;
                            load.load_ready <= 1'b1;
                        end else if (start && wr_ptr != '0) begin
                            target_q        <= target;
                            max_q           <= max_attempts;
                            dp_nonce_addr   <= nonce_addr;
                            dp_width        <= nonce_msb;
                            nonce           <= nonce_start;
                            attempts        <= '0;
                            found_nonce     <= '0;
                            last            <= wr_ptr[ADDR_W-1:0] - ADDR_W'(1);
                            dp_addr         <= wr_ptr[ADDR_W-1:0] - ADDR_W'(1);
                            state           <= S_INIT;
                            dp_state        <= ST_INIT;
                            busy            <= 1'b1;
                            load.load_ready <= 1'b0;
                        end else if (load.load_valid && load.load_ready) begin
                            dp_state        <= ST_WRITE;
                            dp_addr         <= wr_ptr[ADDR_W-1:0];
                            dp_message      <= load.load_data;
                            dp_stopw        <= 1'b0;
                            wr_ptr          <= ptr_inc;
                            load.load_ready <= ptr_room_inc;
                        end
                    end
                    S_INIT: begin
                        blk      <= '0;
                        state    <= S_FETCH;
                        dp_state <= ST_FETCH;
                    end
                    S_FETCH: begin
                        state    <= S_SCHED;
                        dp_state <= ST_SCHED;
                    end
                    S_SCHED: begin
                        rcnt     <= '0;
                        state    <= S_ROUND;
                        dp_state <= ST_ROUND;
                    end
                    S_ROUND: begin
                        if (rcnt != RC_LAST) begin
                            rcnt <= rcnt + 7'd1;
                        end else if (blk == last) begin
                            state    <= S_OUT;
                            dp_state <= ST_OUT;
                        end else begin
                            blk      <= blk + ADDR_W'(1);
                            state    <= S_FETCH;
                            dp_state <= ST_FETCH;
                        end
                    end
                    S_OUT: begin
                        state    <= S_CMP;
                        dp_state <= ST_CMP;
                    end
                    S_CMP: begin
                        if (hit) begin
                            found       <= 1'b1;
                            found_nonce <= nonce;
                            state       <= S_DONE;
                            dp_state    <= ST_DONE;
                        end else begin
                            attempts <= att_inc;
                            nonce    <= nonce + 32'd1;
                            if (max_q != '0 && att_inc == max_q) begin
                                exhausted <= 1'b1;
                                state     <= S_DONE;
                                dp_state  <= ST_DONE;
                            end else begin
                                state    <= S_INIT;
                                dp_state <= ST_INIT;
                            end
                        end
                    end
                    S_DONE: begin
                        state           <= S_IDLE;
                        dp_state        <= ST_IDLE;
                        busy            <= 1'b0;
                        load.load_ready <= ptr_room;
                    end
                    default: begin
                        state    <= S_IDLE;
                        dp_state <= ST_IDLE;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mining_sequencer.sv
// Directed bench for mining_sequencer: load, mine, exhaust, abort,
// fill/clear and nonce wrap, with a dp_state scoreboard queue.
module tb_mining_sequencer;
    import mining_sequencer_pkg::*;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [15:0]  nonce_addr = '0;
    logic [8:0]   nonce_msb = '0;
    logic [31:0]  nonce_start = '0;
    logic [31:0]  max_attempts = '0;
    logic [255:0] target = '0;
    logic [255:0] dp_hash = '0;
    logic [2:0]   dp_state;
    logic [15:0]  dp_addr;
    logic [511:0] dp_message;
    logic         dp_stopw;
    logic [8:0]   dp_width;
    logic [15:0]  dp_nonce_addr;
    logic         busy;
    logic         found;
    logic         exhausted;
    logic [31:0]  found_nonce;
    logic [31:0]  attempts;

    mining_sequencer_if lif ();

    mining_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .load          (lif),
        .start         (start),
        .abort         (abort),
        .nonce_addr    (nonce_addr),
        .nonce_msb     (nonce_msb),
        .nonce_start   (nonce_start),
        .max_attempts  (max_attempts),
        .target        (target),
        .dp_state      (dp_state),
        .dp_addr       (dp_addr),
        .dp_message    (dp_message),
        .dp_stopw      (dp_stopw),
        .dp_width      (dp_width),
        .dp_nonce_addr (dp_nonce_addr),
        .dp_hash       (dp_hash),
        .busy          (busy),
        .found         (found),
        .exhausted     (exhausted),
        .found_nonce   (found_nonce),
        .attempts      (attempts)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] exp_q[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_block(input logic [511:0] d);
        lif.load_valid = 1'b1;
        lif.load_data  = d;
        tick();
        lif.load_valid = 1'b0;
    endtask

    task automatic clear_ptr();
        lif.load_clear = 1'b1;
        tick();
        lif.load_clear = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Start a run and follow it until DONE or the cycle budget expires.
    task automatic run(input int budget, input int switch_at,
                       output int inits, output bit f, output bit x,
                       output logic [31:0] fn, output logic [31:0] at);
        inits = 0; f = 0; x = 0; fn = '0; at = '0;
        pulse_start();
        for (int c = 0; c < budget; c++) begin
            if (dp_state == ST_INIT) begin
                inits++;
                if (inits == switch_at) dp_hash = '0;
            end
            if (found) begin f = 1; fn = found_nonce; at = attempts; end
            if (exhausted) begin x = 1; at = attempts; end
            if (f || x) break;
            tick();
        end
    endtask

    int           inits;
    bit           got_f;
    bit           got_x;
    logic [31:0]  fn;
    logic [31:0]  at;
    logic [2:0]   e;

    initial begin
        lif.load_valid = 1'b0;
        lif.load_clear = 1'b0;
        lif.load_data  = '0;

        repeat (2) tick();
        reset = 1'b0;
        check("rst_state", 256'(dp_state), 256'(ST_IDLE));
        check("rst_stopw", 256'(dp_stopw), 256'd1);
        check("rst_addr", 256'(dp_addr), 256'd0);
        check("rst_msg", 256'(dp_message), 256'd0);
        check("rst_ready", 256'(lif.load_ready), 256'd1);
        check("rst_busy", 256'(busy), 256'd0);
        check("rst_fnonce", 256'(found_nonce), 256'd0);
        check("rst_att", 256'(attempts), 256'd0);

        // Two blocks, winning first attempt
        load_block({16{32'hA5A5_0001}});
        check("wr0_state", 256'(dp_state), 256'(ST_WRITE));
        check("wr0_addr", 256'(dp_addr), 256'd0);
        check("wr0_msg", 256'(dp_message), 256'({16{32'hA5A5_0001}}));
        check("wr0_stopw", 256'(dp_stopw), 256'd0);
        load_block({16{32'h5A5A_0002}});
        check("wr1_addr", 256'(dp_addr), 256'd1);
        tick();
        check("idle_stopw", 256'(dp_stopw), 256'd1);
        check("idle_state", 256'(dp_state), 256'(ST_IDLE));

        nonce_start = 32'd5; target = '1; max_attempts = 0; dp_hash = '0;
        nonce_addr = 16'd1; nonce_msb = 9'd415;
        pulse_start();
        exp_q = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd3, 3'd4, 3'd5,
                  3'd6, 3'd0, 3'd7};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("seq1", 256'(dp_state), 256'(e));
            if (e == 3'd7) begin
                check("seq1_found", 256'(found), 256'd1);
                check("seq1_fnonce", 256'(found_nonce), 256'd5);
                check("seq1_att", 256'(attempts), 256'd0);
                check("seq1_busy", 256'(busy), 256'd1);
                check("seq1_addr", 256'(dp_addr), 256'd1);
                check("seq1_width", 256'(dp_width), 256'd415);
                check("seq1_naddr", 256'(dp_nonce_addr), 256'd1);
            end else begin
                check("seq1_nofound", 256'(found), 256'd0);
                check("seq1_notready", 256'(lif.load_ready), 256'd0);
            end
            if (exp_q.size() > 0) tick();
        end
        tick();
        check("done_busy", 256'(busy), 256'd0);
        check("done_found", 256'(found), 256'd0);
        check("done_ready", 256'(lif.load_ready), 256'd1);
        check("done_hold", 256'(found_nonce), 256'd5);

        // One block, target 0, limit 3
        clear_ptr();
        load_block({16{32'h1111_2222}});
        tick();
        nonce_start = 32'd100; target = '0; max_attempts = 3;
        run(60, 0, inits, got_f, got_x, fn, at);
        check("exh_seen", 256'(got_x), 256'd1);
        check("exh_nofound", 256'(got_f), 256'd0);
        check("exh_inits", 256'(inits), 256'd3);
        check("exh_att", 256'(at), 256'd3);
        tick();
        check("exh_busy", 256'(busy), 256'd0);

        // Nonce wrap, second attempt wins
        nonce_start = 32'hFFFF_FFFF; max_attempts = 0;
        target = 256'd1 << 100; dp_hash = '1;
        run(60, 2, inits, got_f, got_x, fn, at);
        check("wrap_found", 256'(got_f), 256'd1);
        check("wrap_fnonce", 256'(fn), 256'd0);
        check("wrap_att", 256'(at), 256'd1);

        // Nonce wrap, limit 2
        tick();
        nonce_start = 32'hFFFF_FFFF; target = '0; max_attempts = 2;
        run(60, 0, inits, got_f, got_x, fn, at);
        check("wrap_exh", 256'(got_x), 256'd1);
        check("wrap_exh_att", 256'(at), 256'd2);
        tick();

        // Start without blocks is ignored
        clear_ptr();
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            check("empty_busy", 256'(busy), 256'd0);
            check("empty_state", 256'(dp_state), 256'(ST_IDLE));
            tick();
        end

        // Abort during the second ROUND
        load_block({16{32'hDEAD_0001}});
        load_block({16{32'hDEAD_0002}});
        tick();
        target = '1; dp_hash = '0; max_attempts = 0; nonce_start = 32'd9;
        pulse_start();
        exp_q = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd3, 3'd4, 3'd5};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("seq_ab", 256'(dp_state), 256'(e));
            if (exp_q.size() > 0) tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_state", 256'(dp_state), 256'(ST_IDLE));
        check("ab_busy", 256'(busy), 256'd0);
        check("ab_found", 256'(found), 256'd0);
        check("ab_exh", 256'(exhausted), 256'd0);
        check("ab_ready", 256'(lif.load_ready), 256'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ab_quiet", 256'({found, exhausted, busy}), 256'd0);
        end

        // Reset mid-run discards stored blocks
        pulse_start();
        repeat (3) tick();
        check("mid_busy", 256'(busy), 256'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_state", 256'(dp_state), 256'(ST_IDLE));
        check("mrst_busy", 256'(busy), 256'd0);
        check("mrst_ready", 256'(lif.load_ready), 256'd1);
        pulse_start();
        check("mrst_nostart", 256'(busy), 256'd0);

        // Fill to capacity, overflow write, then clear
        for (int i = 0; i < 2000; i++) begin
            load_block(512'(i));
        end
        check("full_addr", 256'(dp_addr), 256'd1999);
        check("full_ready", 256'(lif.load_ready), 256'd0);
        load_block(512'hBAD);
        check("full_nowrite", 256'(dp_state), 256'(ST_IDLE));
        check("full_msg", 256'(dp_message), 256'd1999);
        clear_ptr();
        check("clr_ready", 256'(lif.load_ready), 256'd1);
        load_block(512'h77);
        check("clr_addr", 256'(dp_addr), 256'd0);
        check("clr_state", 256'(dp_state), 256'(ST_WRITE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
